aes_plaintext_unpad: RTL and testbench

// Downstream of aes_decrypt: acts as the Avalon-MM byte-write slave on the decryptor's master2 port.

---
 rtl/aes_pkg.sv | 29 ++
 rtl/aes_pkcs7_check.sv | 24 ++
 rtl/aes_plaintext_unpad.sv | 210 +++++++++++++++++++++
 tb/tb_aes_plaintext_unpad.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES plaintext unpadder: FSM states, the
// 16-byte block type, and the word-count / byte-enable rules for the final block.
package aes_pkg;

    localparam int AES_BLOCK_BYTES = 16;

    typedef enum logic [2:0] {IDLE, FILL, CHECK, EMIT, DONE} unpad_state_t;

    // Byte i of the block lives in element i, so a +:4 slice packs byte 4k at bits [7:0].
    typedef logic [AES_BLOCK_BYTES-1:0][7:0] aes_block_t;

    // Index of the last 32-bit word needed to carry 'keep' bytes (keep==0 still sends one word).
    function automatic logic [1:0] last_word_idx(input logic [4:0] keep);
        if (keep == 5'd0) return 2'd0;
        return 2'((keep - 5'd1) >> 2);
    endfunction

    // Byte enables of the final word of a message.
    function automatic logic [3:0] final_byteen(input logic [4:0] keep);
        if (keep == 5'd0) return 4'h0;
        case (keep[1:0])
            2'd1:    return 4'h1;
            2'd2:    return 4'h3;
            2'd3:    return 4'h7;
            default: return 4'hF;
        endcase
    endfunction

endpackage

// File: rtl/aes_pkcs7_check.sv
// Combinational PKCS#7 padding check of one 16-byte block: reports whether the
// padding is well formed and how many leading plaintext bytes to keep.
module aes_pkcs7_check
    import aes_pkg::*;
(
    input  aes_block_t  blk,
    output logic        pad_ok,
    output logic [4:0]  keep
);

    logic range_ok;

    always_comb begin
        // NOTE: every output gets a value before any conditional logic, so no latch is inferred.
        range_ok = (blk[15] >= 8'd1) && (blk[15] <= 8'd16);
        pad_ok   = range_ok;
        for (int i = 0; i < AES_BLOCK_BYTES; i++) begin
            if (range_ok && (i >= 16 - int'(blk[15])) && (blk[i] != blk[15])) pad_ok = 1'b0;
        end
        // A bad pad forwards the whole block; the host decides what to do with it.
        keep = pad_ok ? 5'(16 - int'(blk[15])) : 5'd16;
    end

endmodule

// File: rtl/aes_plaintext_unpad.sv
// Avalon-MM byte-write slave that gathers decrypted bytes into blocks, strips
// PKCS#7 padding from the final block, and streams 32-bit words with byte enables.
module aes_plaintext_unpad
    import aes_pkg::*;
#(
    parameter int BLK_CNT_W = 5,
    parameter int ADDR_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_start,
    input  logic [BLK_CNT_W-1:0] cfg_num_blocks,
    input  logic                 s_write,
    input  logic [ADDR_W-1:0]    s_address,
    input  logic [7:0]           s_writedata,
    output logic                 s_waitrequest,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_data,
    output logic [3:0]           out_byteen,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done,
    output logic                 pad_error,
    output logic                 seq_error
);

    localparam int CNT_W = BLK_CNT_W + 4;

    unpad_state_t         state_q, state_d;
    aes_block_t           buf_q, buf_d;
    logic [CNT_W-1:0]     byte_cnt_q, byte_cnt_d;
    logic [BLK_CNT_W-1:0] num_blocks_q, num_blocks_d;
    logic [4:0]           keep_q, keep_d;
    logic [1:0]           word_q, word_d;
    logic                 last_blk_q, last_blk_d;
    logic                 out_valid_q, out_valid_d;
    logic [31:0]          out_data_q, out_data_d;
    logic [3:0]           out_byteen_q, out_byteen_d;
    logic                 out_last_q, out_last_d;
    logic                 done_q, done_d;
    logic                 pad_error_q, pad_error_d;
    logic                 seq_error_q, seq_error_d;

    logic       chk_ok;
    logic [4:0] chk_keep;
    logic       in_last_blk, load_word, clear_word, load_last_blk, final_word;
    logic [1:0] load_idx;
    logic [4:0] load_keep;

    aes_pkcs7_check u_check (
        .blk    (buf_q),
        .pad_ok (chk_ok),
        .keep   (chk_keep)
    );

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        byte_cnt_d   = byte_cnt_q;
        num_blocks_d = num_blocks_q;
        keep_d       = keep_q;
        word_d       = word_q;
        last_blk_d   = last_blk_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_byteen_d = out_byteen_q;
        out_last_d   = out_last_q;
        done_d       = done_q;
        pad_error_d  = pad_error_q;
        seq_error_d  = seq_error_q;
        load_word     = 1'b0;
        clear_word    = 1'b0;
        load_idx      = 2'd0;
        load_keep     = keep_q;
        load_last_blk = last_blk_q;
        final_word    = 1'b0;
        in_last_blk   = (byte_cnt_q[CNT_W-1:4] == num_blocks_q - BLK_CNT_W'(1));

        case (state_q)
            IDLE, DONE: begin
                if (cfg_start) begin
                    num_blocks_d = cfg_num_blocks;
                    byte_cnt_d   = '0;
                    done_d       = 1'b0;
                    pad_error_d  = 1'b0;
                    seq_error_d  = 1'b0;
                    if (cfg_num_blocks == '0) begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        pad_error_d = 1'b1;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                if (s_write) begin
                    if (s_address == ADDR_W'(byte_cnt_q)) begin
                        buf_d[s_address[3:0]] = s_writedata;
                        byte_cnt_d            = byte_cnt_q + CNT_W'(1);
                        if (s_address[3:0] == 4'hF) begin
                            if (in_last_blk) begin
                                state_d = CHECK;
                            end else begin
                                // Word 0 is already in the buffer, so emission starts on this edge.
                                state_d       = EMIT;
                                keep_d        = 5'd16;
                                last_blk_d    = 1'b0;
                                word_d        = 2'd0;
                                load_word     = 1'b1;
                                load_keep     = 5'd16;
                                load_last_blk = 1'b0;
                            end
                        end
                    end else begin
                        seq_error_d = 1'b1;
                    end
                end
            end
            CHECK: begin
                state_d       = EMIT;
                keep_d        = chk_keep;
                last_blk_d    = 1'b1;
                word_d        = 2'd0;
                if (!chk_ok) pad_error_d = 1'b1;
                load_word     = 1'b1;
                load_keep     = chk_keep;
                load_last_blk = 1'b1;
            end
            EMIT: begin
                if (out_valid_q && out_ready) begin
                    if (out_last_q) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        clear_word = 1'b1;
                    end else if (word_q == last_word_idx(keep_q)) begin
                        state_d    = FILL;
                        clear_word = 1'b1;
                    end else begin
                        word_d    = word_q + 2'd1;
                        load_word = 1'b1;
                        load_idx  = word_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_word) begin
            final_word   = load_last_blk && (load_idx == last_word_idx(load_keep));
            out_valid_d  = 1'b1;
            out_data_d   = buf_q[{load_idx, 2'b00} +: 4];
            out_byteen_d = final_word ? final_byteen(load_keep) : 4'hF;
            out_last_d   = final_word;
        end else if (clear_word) begin
            out_valid_d  = 1'b0;
            out_data_d   = '0;
            out_byteen_d = '0;
            out_last_d   = 1'b0;
        end
    end

    // NOTE: non-blocking assignments, so every flop samples the pre-edge value of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            // NOTE: the block buffer is a plain register array, so it is cleared with everything else.
            buf_q        <= '0;
            byte_cnt_q   <= '0;
            num_blocks_q <= '0;
            keep_q       <= '0;
            word_q       <= '0;
            last_blk_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_byteen_q <= '0;
            out_last_q   <= 1'b0;
            done_q       <= 1'b0;
            pad_error_q  <= 1'b0;
            seq_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            byte_cnt_q   <= byte_cnt_d;
            num_blocks_q <= num_blocks_d;
            keep_q       <= keep_d;
            word_q       <= word_d;
            last_blk_q   <= last_blk_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_byteen_q <= out_byteen_d;
            out_last_q   <= out_last_d;
            done_q       <= done_d;
            pad_error_q  <= pad_error_d;
            seq_error_q  <= seq_error_d;
        end
    end

    assign s_waitrequest = (state_q != FILL);
    assign busy          = (state_q == FILL) || (state_q == CHECK) || (state_q == EMIT);
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_byteen    = out_byteen_q;
    assign out_last      = out_last_q;
    assign done          = done_q;
    assign pad_error     = pad_error_q;
    assign seq_error     = seq_error_q;

endmodule

// File: tb/tb_aes_plaintext_unpad.sv
// Directed bench for aes_plaintext_unpad: hand-computed words per message,
// padding/sequence error cases, stalled stream stability and reset in EMIT.
module tb_aes_plaintext_unpad;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  be;
        logic        last;
    } word_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start;
    logic [4:0]  cfg_num_blocks;
    logic        s_write;
    logic [31:0] s_address;
    logic [7:0]  s_writedata;
    logic        s_waitrequest;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_byteen;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        pad_error;
    logic        seq_error;

    int    n_checks = 0;
    int    n_pass   = 0;
    int    ready_mode = 0;
    int    rdy_cyc    = 0;
    logic  [7:0] msg [0:63];
    word_t got_q[$];
    word_t exp_q[$];
    logic  prev_stall = 1'b0;
    logic  [36:0] prev_word = '0;

    always #5 clk = ~clk;

    aes_plaintext_unpad #(.BLK_CNT_W(5), .ADDR_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_start      (cfg_start),
        .cfg_num_blocks (cfg_num_blocks),
        .s_write        (s_write),
        .s_address      (s_address),
        .s_writedata    (s_writedata),
        .s_waitrequest  (s_waitrequest),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_byteen     (out_byteen),
        .out_last       (out_last),
        .busy           (busy),
        .done           (done),
        .pad_error      (pad_error),
        .seq_error      (seq_error)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Words are logged at the falling edge when a handshake is set up for the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", {out_valid, out_data, out_byteen, out_last}, {1'b1, prev_word});
            if (out_valid && out_ready) got_q.push_back(word_t'{out_data, out_byteen, out_last});
            prev_stall <= out_valid && !out_ready;
            prev_word  <= {out_data, out_byteen, out_last};
        end
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (rdy_cyc % 3 == 0);
                default: out_ready = 1'b0;
            endcase
            rdy_cyc++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_msg(input logic [4:0] n);
        got_q.delete();
        exp_q.delete();
        cfg_num_blocks = n;
        cfg_start      = 1'b1;
        tick();
        cfg_start      = 1'b0;
    endtask

    task automatic write_byte(input logic [31:0] a, input logic [7:0] d);
        int guard = 0;
        while (s_waitrequest && guard < 500) begin
            tick();
            guard++;
        end
        check("write_wait", {63'd0, s_waitrequest}, 64'd0);
        s_write     = 1'b1;
        s_address   = a;
        s_writedata = d;
        tick();
        s_write     = 1'b0;
    endtask

    task automatic send_bytes(input int first, input int count);
        for (int i = first; i < first + count; i++) write_byte(32'(i), msg[i]);
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [3:0] be, input logic last);
        exp_q.push_back(word_t'{d, be, last});
    endtask

    task automatic wait_done(input string tag);
        int guard = 0;
        while (!done && guard < 1000) begin
            tick();
            guard++;
        end
        check({tag, "_done"}, {63'd0, done}, 64'd1);
    endtask

    task automatic compare_words(input string tag);
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_w%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    endtask

    // {done, busy, pad_error, seq_error}
    task automatic check_flags(input string tag, input logic [3:0] exp);
        check(tag, {60'd0, done, busy, pad_error, seq_error}, {60'd0, exp});
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, {21'd0, s_waitrequest, out_valid, out_last, busy, done, pad_error, seq_error,
                    out_byteen, out_data},
                   {21'd0, 1'b1, 6'b0, 4'h0, 32'h0});
    endtask

    initial begin
        rst            = 1'b1;
        cfg_start      = 1'b0;
        cfg_num_blocks = '0;
        s_write        = 1'b0;
        s_address      = '0;
        s_writedata    = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // One block, pad 04 x4: keep 12 -> three full words.
        for (int i = 0; i < 12; i++) msg[i] = 8'(8'hA0 + i);
        for (int i = 12; i < 16; i++) msg[i] = 8'h04;
        start_msg(5'd1);
        check_flags("t1_busy", 4'b0100);
        send_bytes(0, 16);
        expect_word(32'hA3A2A1A0, 4'hF, 1'b0);
        expect_word(32'hA7A6A5A4, 4'hF, 1'b0);
        expect_word(32'hABAAA9A8, 4'hF, 1'b1);
        wait_done("t1");
        compare_words("t1");
        check_flags("t1_flags", 4'b1000);

        // Two blocks, second padded with 05 x5: keep 11 -> F,F,7 last.
        for (int i = 0; i < 16; i++) msg[i] = 8'(i);
        for (int j = 0; j < 11; j++) msg[16 + j] = 8'(8'h50 + j);
        for (int j = 11; j < 16; j++) msg[16 + j] = 8'h05;
        start_msg(5'd2);
        for (int i = 0; i < 32; i++) begin
            write_byte(32'(i), msg[i]);
            if (i == 15) check("t2_lat_nonlast", {63'd0, out_valid}, 64'd1);
            if (i == 31) begin
                check("t2_lat_last_a", {63'd0, out_valid}, 64'd0);
                tick();
                check("t2_lat_last_b", {63'd0, out_valid}, 64'd1);
            end
        end
        expect_word(32'h03020100, 4'hF, 1'b0);
        expect_word(32'h07060504, 4'hF, 1'b0);
        expect_word(32'h0B0A0908, 4'hF, 1'b0);
        expect_word(32'h0F0E0D0C, 4'hF, 1'b0);
        expect_word(32'h53525150, 4'hF, 1'b0);
        expect_word(32'h57565554, 4'hF, 1'b0);
        expect_word(32'h055A5958, 4'h7, 1'b1);
        wait_done("t2");
        compare_words("t2");
        check_flags("t2_flags", 4'b1000);

        // Out-of-order address 5 is dropped; the resent 4..15 completes normally.
        for (int i = 0; i < 8; i++) msg[i] = 8'(8'h30 + i);
        for (int i = 8; i < 16; i++) msg[i] = 8'h08;
        start_msg(5'd1);
        send_bytes(0, 4);
        write_byte(32'd5, 8'hEE);
        check("t5_seq_flag", {63'd0, seq_error}, 64'd1);
        send_bytes(4, 12);
        expect_word(32'h33323130, 4'hF, 1'b0);
        expect_word(32'h37363534, 4'hF, 1'b1);
        wait_done("t5");
        compare_words("t5");
        check_flags("t5_flags", 4'b1001);

        // Pad byte 03 but byte 13 is 02: invalid, all 16 bytes forwarded.
        for (int i = 0; i < 13; i++) msg[i] = 8'(8'hC0 + i);
        msg[13] = 8'h02;
        msg[14] = 8'h03;
        msg[15] = 8'h03;
        start_msg(5'd1);
        send_bytes(0, 16);
        expect_word(32'hC3C2C1C0, 4'hF, 1'b0);
        expect_word(32'hC7C6C5C4, 4'hF, 1'b0);
        expect_word(32'hCBCAC9C8, 4'hF, 1'b0);
        expect_word(32'h030302CC, 4'hF, 1'b1);
        wait_done("t4");
        compare_words("t4");
        check_flags("t4_flags", 4'b1010);

        // out_ready high one cycle in three; pad 02 x2 -> keep 14, last byteen 3.
        ready_mode = 1;
        for (int i = 0; i < 14; i++) msg[i] = 8'(8'h70 + i);
        msg[14] = 8'h02;
        msg[15] = 8'h02;
        start_msg(5'd1);
        send_bytes(0, 16);
        expect_word(32'h73727170, 4'hF, 1'b0);
        expect_word(32'h77767574, 4'hF, 1'b0);
        expect_word(32'h7B7A7978, 4'hF, 1'b0);
        expect_word(32'h02027D7C, 4'h3, 1'b1);
        wait_done("t6");
        compare_words("t6");
        check_flags("t6_flags", 4'b1000);

        // Reset asserted while EMIT is stalled.
        ready_mode = 2;
        for (int i = 0; i < 12; i++) msg[i] = 8'(8'hA0 + i);
        for (int i = 12; i < 16; i++) msg[i] = 8'h04;
        start_msg(5'd1);
        send_bytes(0, 16);
        begin
            int guard = 0;
            while (!out_valid && guard < 50) begin
                tick();
                guard++;
            end
        end
        check("t7_emit_valid", {32'd0, out_valid, out_data[30:0]}, {32'd0, 1'b1, 31'h23A2A1A0});
        repeat (3) tick();
        rst = 1'b1;
        #2;
        check_reset_outputs("t7_reset");
        tick();
        rst = 1'b0;
        ready_mode = 0;
        tick();

        // All-pad block (p=16): one word, byteen 0, last.
        for (int i = 0; i < 16; i++) msg[i] = 8'h10;
        start_msg(5'd1);
        send_bytes(0, 16);
        expect_word(32'h10101010, 4'h0, 1'b1);
        wait_done("t3");
        compare_words("t3");
        check_flags("t3_flags", 4'b1000);

        // N=0 is illegal: straight to DONE with pad_error.
        start_msg(5'd0);
        check("t8_illegal_n", {60'd0, busy, pad_error, seq_error, s_waitrequest}, {60'd0, 4'b0101});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
